// File: rtl/pzc_corr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pzc_corr_scheduler
// Description : Baseline-correction sequencer for the PZC datapath. Waits out
//               the bunch train, averages K_CORR negative samples and hands
//               the mean over valid/ack. Owns the shadowed runtime M factor.
//               Optional window timeout: define PZC_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pzc_corr_scheduler #(
    parameter int NBITS_OUT  = 28,
    parameter int MBITS      = 16,
    parameter int M_DEFAULT  = 454,
    parameter int K_CORR     = 16,
    parameter int SETTLE_CYC = 16,
    parameter int WIN_MAX    = 4000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bt_mask_out,
    input  logic signed [NBITS_OUT-1:0] pzc_out,
    input  logic                        cfg_wr,
    input  logic        [MBITS-1:0]     cfg_m_factor,
    output logic        [MBITS-1:0]     m_factor,
    output logic                        corr_valid,
    output logic signed [NBITS_OUT-1:0] corr_value,
    input  logic                        corr_ack,
    output logic        [1:0]           state,
    output logic        [15:0]          corr_count,
    output logic                        timeout_pulse
);

    localparam int c_log2k = $clog2(K_CORR);
    localparam int c_sum_w = NBITS_OUT + c_log2k;
    localparam int c_neg_w = c_log2k + 1;
    localparam int c_set_w = $clog2(SETTLE_CYC);

    localparam logic [c_neg_w-1:0] c_neg_last    = c_neg_w'(K_CORR - 1);
    localparam logic [c_set_w-1:0] c_settle_last = c_set_w'(SETTLE_CYC - 1);
    localparam logic [c_set_w-1:0] c_settle_one  = c_set_w'(1);
    localparam logic [MBITS-1:0]   c_m_default   = MBITS'(M_DEFAULT);

    generate
        if (K_CORR < 2 || (K_CORR & (K_CORR - 1)) != 0 || SETTLE_CYC < 2 || WIN_MAX < 2) begin : g_param_check
            $error("pzc_corr_scheduler: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_APPLY  = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic        [c_set_w-1:0]   r_settle_cnt;
    logic        [c_set_w-1:0]   w_settle_nxt;
    logic        [c_sum_w-1:0]   r_sum;
    logic        [c_sum_w-1:0]   w_sum_nxt;
    logic        [c_sum_w-1:0]   w_pzc_ext;
    logic        [c_sum_w-1:0]   w_sum_add;
    logic        [c_neg_w-1:0]   r_neg_cnt;
    logic        [c_neg_w-1:0]   w_neg_nxt;
    logic                        w_is_neg;
    logic                        w_last_neg;
    logic                        r_corr_valid;
    logic                        w_valid_nxt;
    logic signed [NBITS_OUT-1:0] r_corr_value;
    logic signed [NBITS_OUT-1:0] w_value_nxt;
    logic        [15:0]          r_corr_count;
    logic        [15:0]          w_count_nxt;
    logic        [MBITS-1:0]     r_m_factor;
    logic        [MBITS-1:0]     r_shadow;
    logic                        r_shadow_pend;

    assign w_is_neg   = pzc_out[NBITS_OUT-1];
    assign w_pzc_ext  = {{c_log2k{pzc_out[NBITS_OUT-1]}}, pzc_out};
    assign w_sum_add  = r_sum + w_pzc_ext;
    assign w_last_neg = w_is_neg && (r_neg_cnt == c_neg_last);

`ifdef PZC_SCHED_TIMEOUT_EN
    localparam int c_win_w = $clog2(WIN_MAX);
    localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WIN_MAX - 1);

    logic [c_win_w-1:0] r_win_cnt;
    logic [c_win_w-1:0] w_win_nxt;
    logic               w_win_expired;
    logic               r_timeout_pulse;
    logic               w_pulse_nxt;

    assign w_win_expired = (r_win_cnt == c_win_last);

    // Held at zero outside ACCUM so every window starts from a fresh count.
    always_comb begin
        w_win_nxt = '0;
        if (r_state == ST_ACCUM && !w_win_expired) begin
            w_win_nxt = r_win_cnt + c_win_w'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_cnt       <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_win_cnt       <= w_win_nxt;
            r_timeout_pulse <= w_pulse_nxt;
        end
    end

    assign timeout_pulse = r_timeout_pulse;
`else
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle_cnt;
        w_sum_nxt    = r_sum;
        w_neg_nxt    = r_neg_cnt;
        w_valid_nxt  = r_corr_valid;
        w_value_nxt  = r_corr_value;
        w_count_nxt  = r_corr_count;
`ifdef PZC_SCHED_TIMEOUT_EN
        w_pulse_nxt  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!bt_mask_out) begin
                    w_state_nxt  = ST_SETTLE;
                    w_settle_nxt = c_settle_one;
                end
            end
            ST_SETTLE: begin
                if (bt_mask_out) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_settle_cnt == c_settle_last) begin
                    w_state_nxt = ST_ACCUM;
                    w_sum_nxt   = '0;
                    w_neg_nxt   = '0;
                end else begin
                    w_settle_nxt = r_settle_cnt + c_settle_one;
                end
            end
            ST_ACCUM: begin
                if (bt_mask_out) begin
                    w_state_nxt = ST_IDLE;
                    w_sum_nxt   = '0;
                    w_neg_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end else begin
                    if (w_is_neg) begin
                        w_sum_nxt = w_sum_add;
                        w_neg_nxt = r_neg_cnt + c_neg_w'(1);
                    end
                    // Dropping the low log2(K) bits is the floor-rounded mean.
                    if (w_last_neg) begin
                        w_value_nxt = w_sum_add[c_sum_w-1:c_log2k];
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_APPLY;
                    end
`ifdef PZC_SCHED_TIMEOUT_EN
                    else if (w_win_expired) begin
                        w_pulse_nxt = 1'b1;
                        w_sum_nxt   = '0;
                        w_neg_nxt   = '0;
                    end
`endif
                end
            end
            ST_APPLY: begin
                if (corr_ack) begin
                    w_valid_nxt = 1'b0;
                    w_sum_nxt   = '0;
                    w_neg_nxt   = '0;
                    if (r_corr_count != 16'hFFFF) begin
                        w_count_nxt = r_corr_count + 16'd1;
                    end
                    w_state_nxt = bt_mask_out ? ST_IDLE : ST_ACCUM;
                end else if (bt_mask_out) begin
                    w_valid_nxt = 1'b0;
                    w_sum_nxt   = '0;
                    w_neg_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle_cnt <= '0;
            r_sum        <= '0;
            r_neg_cnt    <= '0;
            r_corr_valid <= 1'b0;
            r_corr_value <= '0;
            r_corr_count <= '0;
        end else begin
            r_settle_cnt <= w_settle_nxt;
            r_sum        <= w_sum_nxt;
            r_neg_cnt    <= w_neg_nxt;
            r_corr_valid <= w_valid_nxt;
            r_corr_value <= w_value_nxt;
            r_corr_count <= w_count_nxt;
        end
    end

    // A write landing together with a pending apply keeps pend set, so the last write wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_factor    <= c_m_default;
            r_shadow      <= c_m_default;
            r_shadow_pend <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && r_shadow_pend) begin
                r_m_factor <= r_shadow;
            end
            if (cfg_wr) begin
                r_shadow      <= cfg_m_factor;
                r_shadow_pend <= 1'b1;
            end else if (r_state == ST_IDLE) begin
                r_shadow_pend <= 1'b0;
            end
        end
    end

    assign m_factor   = r_m_factor;
    assign corr_valid = r_corr_valid;
    assign corr_value = r_corr_value;
    assign corr_count = r_corr_count;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pzc_corr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pzc_corr_scheduler
// Description : Self-checking bench for pzc_corr_scheduler against a
//               queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pzc_corr_scheduler;

    localparam int NB      = 28;
    localparam int MB      = 16;
    localparam int K       = 16;
    localparam int SETTLE  = 16;
    localparam int WIN_MAX = 100;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 bt_mask_out = 1'b1;
    logic signed [NB-1:0] pzc_out = '0;
    logic                 cfg_wr = 1'b0;
    logic [MB-1:0]        cfg_m_factor = '0;
    logic                 corr_ack = 1'b0;
    logic [MB-1:0]        m_factor;
    logic                 corr_valid;
    logic signed [NB-1:0] corr_value;
    logic [1:0]           state;
    logic [15:0]          corr_count;
    logic                 timeout_pulse;

    int n_cmp = 0;
    int n_err = 0;

    pzc_corr_scheduler #(
        .NBITS_OUT (NB),
        .MBITS     (MB),
        .M_DEFAULT (454),
        .K_CORR    (K),
        .SETTLE_CYC(SETTLE),
        .WIN_MAX   (WIN_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bt_mask_out  (bt_mask_out),
        .pzc_out      (pzc_out),
        .cfg_wr       (cfg_wr),
        .cfg_m_factor (cfg_m_factor),
        .m_factor     (m_factor),
        .corr_valid   (corr_valid),
        .corr_value   (corr_value),
        .corr_ack     (corr_ack),
        .state        (state),
        .corr_count   (corr_count),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode number, run of quiet samples, queue of collected negatives.
    int     m_state;
    int     m_quiet;
    int     m_win;
    int     m_count;
    int     m_mf;
    int     m_shadow;
    bit     m_pend;
    bit     m_valid;
    bit     m_pulse;
    longint m_value;
    longint m_negs[$];

    function automatic longint floor_mean();
        longint s = 0;
        longint q;
        foreach (m_negs[i]) s += m_negs[i];
        q = s / K;
        if ((s % K) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        m_state = 0; m_quiet = 0; m_win = 0; m_count = 0;
        m_mf = 454; m_shadow = 454; m_pend = 0;
        m_valid = 0; m_pulse = 0; m_value = 0;
        m_negs.delete();
    endtask

    task automatic model_step(input bit mask, input longint x, input bit wr, input int wd, input bit ack);
        int ns = m_state;
        m_pulse = 0;
        if (m_state == 0 && m_pend) begin m_mf = m_shadow; m_pend = 0; end
        if (wr) begin m_shadow = wd; m_pend = 1; end
        case (m_state)
            0: if (!mask) begin ns = 1; m_quiet = 1; end
            1: begin
                if (mask) ns = 0;
                else begin
                    m_quiet++;
                    if (m_quiet == SETTLE) begin ns = 2; m_negs.delete(); m_win = 0; end
                end
            end
            2: begin
                if (mask) begin ns = 0; m_negs.delete(); m_valid = 0; end
                else begin
                    m_win++;
                    if (x < 0) m_negs.push_back(x);
                    if (m_negs.size() == K) begin
                        m_value = floor_mean(); m_valid = 1; m_negs.delete(); ns = 3;
                    end
`ifdef PZC_SCHED_TIMEOUT_EN
                    else if (m_win == WIN_MAX) begin m_pulse = 1; m_negs.delete(); m_win = 0; end
`endif
                end
            end
            default: begin
                if (ack) begin
                    m_count = (m_count < 65535) ? m_count + 1 : 65535;
                    m_valid = 0; m_win = 0;
                    ns = mask ? 0 : 2;
                end else if (mask) begin
                    m_valid = 0; ns = 0;
                end
            end
        endcase
        m_state = ns;
    endtask

    task automatic cycle(input bit mask, input longint x, input bit wr, input int wd, input bit ack);
        bt_mask_out  = mask;
        pzc_out      = NB'(x);
        cfg_wr       = wr;
        cfg_m_factor = MB'(wd);
        corr_ack     = ack;
        @(posedge clk);
        model_step(mask, x, wr, wd, ack);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_cmp++; if (m_factor !== 16'd454) begin n_err++; $display("FAIL reset_mfactor: got %0d expected 454", m_factor); end
        n_cmp++; if (corr_valid !== 1'b0 || corr_value !== '0) begin n_err++; $display("FAIL reset_corr: got v=%0b val=%0d expected 0/0", corr_valid, corr_value); end
        n_cmp++; if (corr_count !== 16'd0 || timeout_pulse !== 1'b0) begin n_err++; $display("FAIL reset_count: got cnt=%0d to=%0b expected 0/0", corr_count, timeout_pulse); end
        rst = 1'b0;
        cycle(0, -5, 0, 0, 1);
        n_cmp++; if (corr_valid !== 1'b0 || state !== 2'd1) begin n_err++; $display("FAIL reset_release: got v=%0b st=%0d expected 0/1", corr_valid, state); end
        cycle(1, 0, 0, 0, 0);
    endtask

    task automatic test_settle_correct();
        cycle(1, 0, 0, 0, 0);
        for (int i = 1; i <= SETTLE; i++) begin
            cycle(0, 7, 0, 0, 0);
            n_cmp++;
            if (state !== ((i < SETTLE) ? 2'd1 : 2'd2)) begin
                n_err++; $display("FAIL settle_state[%0d]: got %0d expected %0d", i, state, (i < SETTLE) ? 1 : 2);
            end
        end
        for (int i = 0; i < K; i++) begin
            cycle(0, 5, 0, 0, 0);
            cycle(0, -32, 0, 0, 0);
            n_cmp++;
            if (corr_valid !== (i == K - 1) || state !== ((i == K - 1) ? 2'd3 : 2'd2)) begin
                n_err++; $display("FAIL accum_progress[%0d]: got v=%0b st=%0d expected v=%0b", i, corr_valid, state, i == K - 1);
            end
        end
        n_cmp++; if (corr_value !== -28'sd32) begin n_err++; $display("FAIL corr_value_32: got %0d expected -32", corr_value); end
        for (int i = 0; i < 3; i++) begin
            cycle(0, -100, 0, 0, 0);
            n_cmp++;
            if (corr_valid !== 1'b1 || corr_value !== -28'sd32 || state !== 2'd3) begin
                n_err++; $display("FAIL apply_hold[%0d]: got v=%0b val=%0d st=%0d expected 1/-32/3", i, corr_valid, corr_value, state);
            end
        end
        cycle(0, 0, 0, 0, 1);
        n_cmp++;
        if (corr_valid !== 1'b0 || corr_count !== 16'd1 || state !== 2'd2) begin
            n_err++; $display("FAIL ack_1: got v=%0b cnt=%0d st=%0d expected 0/1/2", corr_valid, corr_count, state);
        end
    endtask

    task automatic test_rounding();
        for (int i = 0; i < K; i++) cycle(0, (i == 7) ? -2 : -1, 0, 0, 0);
        n_cmp++;
        if (corr_valid !== 1'b1 || corr_value !== -28'sd2) begin
            n_err++; $display("FAIL round_value: got v=%0b val=%0d expected 1/-2", corr_valid, corr_value);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(0, -777, 0, 0, 0);
            n_cmp++;
            if (corr_value !== -28'sd2 || state !== 2'd3 || corr_valid !== 1'b1) begin
                n_err++; $display("FAIL round_stable[%0d]: got val=%0d st=%0d v=%0b expected -2/3/1", i, corr_value, state, corr_valid);
            end
        end
        cycle(0, 0, 0, 0, 1);
        n_cmp++;
        if (corr_count !== 16'(m_count) || state !== 2'd2) begin
            n_err++; $display("FAIL round_ack: got cnt=%0d st=%0d expected %0d/2", corr_count, state, m_count);
        end
    endtask

    task automatic test_abort();
        longint x;
        longint s = 0;
        for (int i = 0; i < 10; i++) cycle(0, -longint'($urandom_range(1, 1000)), 0, 0, 0);
        cycle(1, -3, 0, 0, 0);
        n_cmp++;
        if (state !== 2'd0 || corr_valid !== 1'b0) begin
            n_err++; $display("FAIL abort_idle: got st=%0d v=%0b expected 0/0", state, corr_valid);
        end
        for (int i = 0; i < SETTLE; i++) cycle(0, 1, 0, 0, 0);
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL abort_resettle: got %0d expected 2", state); end
        for (int i = 0; i < K; i++) begin
            x = -longint'($urandom_range(1, 1 << 20));
            s += x;
            cycle(0, x, 0, 0, 0);
        end
        n_cmp++;
        if (corr_valid !== 1'b1 || corr_value !== NB'(s >>> 4) || corr_value !== NB'(m_value)) begin
            n_err++; $display("FAIL abort_fresh: got v=%0b val=%0d expected 1/%0d", corr_valid, corr_value, s >>> 4);
        end
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_config();
        cycle(0, 3, 1, 1000, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 4, 0, 0, 0);
            n_cmp++; if (m_factor !== 16'd454) begin n_err++; $display("FAIL cfg_hold[%0d]: got %0d expected 454", i, m_factor); end
        end
        cycle(1, 0, 0, 0, 0);
        n_cmp++; if (m_factor !== 16'd454 || state !== 2'd0) begin n_err++; $display("FAIL cfg_idle_entry: got mf=%0d st=%0d expected 454/0", m_factor, state); end
        cycle(1, 0, 0, 0, 0);
        n_cmp++; if (m_factor !== 16'd1000) begin n_err++; $display("FAIL cfg_apply: got %0d expected 1000", m_factor); end
        cycle(1, 0, 1, 700, 0);
        cycle(1, 0, 1, 800, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 0);
            n_cmp++;
            if (m_factor !== 16'd800 || m_factor !== MB'(m_mf)) begin
                n_err++; $display("FAIL cfg_last_wins[%0d]: got %0d expected 800", i, m_factor);
            end
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int exp_pulses;
        longint exp_val;
`ifdef PZC_SCHED_TIMEOUT_EN
        exp_pulses = 1; exp_val = -8;
`else
        exp_pulses = 0; exp_val = -16;
`endif
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < SETTLE; i++) cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < WIN_MAX; i++) begin
            cycle(0, (i < 3) ? -50 : 9, 0, 0, 0);
            if (timeout_pulse === 1'b1) pulses++;
            n_cmp++;
            if (timeout_pulse !== m_pulse) begin
                n_err++; $display("FAIL timeout_cycle[%0d]: got %0b expected %0b", i, timeout_pulse, m_pulse);
            end
        end
        n_cmp++;
        if (pulses != exp_pulses || state !== 2'd2) begin
            n_err++; $display("FAIL timeout_count: got pulses=%0d st=%0d expected %0d/2", pulses, state, exp_pulses);
        end
        for (int i = 0; i < K; i++) cycle(0, -8, 0, 0, 0);
        n_cmp++;
        if (corr_valid !== 1'b1 || corr_value !== NB'(exp_val)) begin
            n_err++; $display("FAIL timeout_window: got v=%0b val=%0d expected 1/%0d", corr_valid, corr_value, exp_val);
        end
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        bit     mask = 0;
        longint x;
        logic signed [NB-1:0] r;
        bit     wr;
        int     wd;
        for (int i = 0; i < 3000; i++) begin
            if (mask) mask = ($urandom_range(0, 99) < 10) ? 1'b0 : 1'b1;
            else      mask = ($urandom_range(0, 99) < 1)  ? 1'b1 : 1'b0;
            r = NB'($urandom);
            case ($urandom_range(0, 3))
                0: x = 0;
                1: x = r;
                2: x = -longint'($urandom_range(1, 5000));
                default: x = longint'($urandom_range(0, 5000));
            endcase
            wr = ($urandom_range(0, 99) < 2);
            wd = int'($urandom_range(0, 65535));
            cycle(mask, x, wr, wd, $urandom_range(0, 9) < 3);
            n_cmp++;
            if (state !== 2'(m_state) || m_factor !== MB'(m_mf) || corr_valid !== m_valid ||
                corr_count !== 16'(m_count) || timeout_pulse !== m_pulse ||
                (m_valid && corr_value !== NB'(m_value))) begin
                n_err++;
                $display("FAIL rand_cycle[%0d]: got st=%0d mf=%0d v=%0b val=%0d cnt=%0d to=%0b expected st=%0d mf=%0d v=%0b val=%0d cnt=%0d to=%0b",
                         i, state, m_factor, corr_valid, corr_value, corr_count, timeout_pulse,
                         m_state, m_mf, m_valid, m_value, m_count, m_pulse);
            end
        end
    endtask

    task automatic test_reset_midrun();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < SETTLE; i++) cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, -9, 0, 0, 0);
        cycle(0, -9, 1, 999, 0);
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL midrun_accum: got %0d expected 2", state); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        n_cmp++;
        if (state !== 2'd0 || m_factor !== 16'd454 || corr_valid !== 1'b0 || corr_count !== 16'd0) begin
            n_err++; $display("FAIL midrun_reset: got st=%0d mf=%0d v=%0b cnt=%0d expected 0/454/0/0", state, m_factor, corr_valid, corr_count);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 0);
            n_cmp++;
            if (m_factor !== 16'd454 || corr_valid !== 1'b0) begin
                n_err++; $display("FAIL midrun_discard[%0d]: got mf=%0d v=%0b expected 454/0", i, m_factor, corr_valid);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_settle_correct();
        test_rounding();
        test_abort();
        test_config();
        test_timeout();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
